byte_word_packer: RTL and testbench



---
 rtl/byte_word_packer_if.sv | 22 ++
 rtl/byte_word_packer.sv | 85 ++++++++
 tb/tb_byte_word_packer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_word_packer_if.sv
// Byte-stream input handshake and word-memory write port of the byte-to-word packer.
interface byte_word_packer_if #(parameter int ADDR_W = 6);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              flush;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [1:0]        fill_level;
    logic              wrapped;

    modport master (
        output in_valid, in_byte, flush,
        input  in_ready, mem_we, mem_addr, mem_data, fill_level, wrapped
    );

    modport slave (
        input  in_valid, in_byte, flush,
        output in_ready, mem_we, mem_addr, mem_data, fill_level, wrapped
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs four bytes little-endian into a 32-bit word and writes it to an
// auto-incrementing word address; flush writes a zero-padded partial word.
module byte_word_packer #(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    byte_word_packer_if.slave   bus
);
    typedef enum logic {FILL, WRITE} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic [31:0]       asm_reg, asm_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic              wrapped_reg, wrapped_next;
    logic              accept;

    assign accept = bus.in_valid && bus.in_ready;

    // Each lane captures the byte when it is the current lane; the write cycle clears all lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[8*gi +: 8] =
                (state_reg == WRITE)               ? 8'h00 :
                (accept && cnt_reg == 2'(gi))      ? bus.in_byte :
                                                     asm_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FILL;
            cnt_reg     <= 2'd0;
            asm_reg     <= 32'd0;
            wr_ptr_reg  <= '0;
            wrapped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            asm_reg     <= asm_next;
            wr_ptr_reg  <= wr_ptr_next;
            wrapped_reg <= wrapped_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wr_ptr_next  = wr_ptr_reg;
        wrapped_next = wrapped_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    // A flush arriving with a byte includes that byte in the word.
                    if (cnt_reg == 2'd3 || bus.flush) begin
                        state_next = WRITE;
                    end
                    if (cnt_reg != 2'd3) begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end else if (bus.flush && cnt_reg != 2'd0) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next  = FILL;
                cnt_next    = 2'd0;
                wr_ptr_next = wr_ptr_reg + 1'b1;
                if (&wr_ptr_reg) begin
                    wrapped_next = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // in_ready is a function of state only, gated low while reset is held.
    assign bus.in_ready   = (state_reg == FILL) && !rst;
    assign bus.mem_we     = (state_reg == WRITE);
    assign bus.mem_addr   = wr_ptr_reg;
    assign bus.mem_data   = asm_reg;
    assign bus.fill_level = cnt_reg;
    assign bus.wrapped    = wrapped_reg;
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: a queue-based byte model predicts words,
// a monitor compares every memory write against the expected queue.
module tb_byte_word_packer;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    byte_word_packer_if #(.ADDR_W(ADDR_W)) bus ();

    byte_word_packer #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] pend[$];
    wr_t        exp_q[$];
    int         ptr;
    bit         busy;
    bit         wrap_pend;
    bit         exp_wrapped;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        exp_q.delete();
        ptr = 0;
        busy = 0;
        wrap_pend = 0;
        exp_wrapped = 0;
    endtask

    task automatic emit();
        wr_t w;
        w.addr = ptr;
        w.data = 32'd0;
        foreach (pend[k]) w.data = w.data + (32'(pend[k]) << (8 * k));
        exp_q.push_back(w);
        $display("issue word 0x%08h -> addr %0d", w.data, w.addr);
        pend.delete();
        busy = 1;
        if (ptr == DEPTH - 1) wrap_pend = 1;
        ptr = (ptr + 1) % DEPTH;
    endtask

    // Called just after a rising edge: drive, check at falling edge, update model, advance.
    task automatic step(input bit v, input logic [7:0] b, input bit f, output bit acc);
        bus.in_valid = v;
        bus.in_byte  = b;
        bus.flush    = f;
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready), 64'(!busy));
        check("wrapped", 64'(bus.wrapped), 64'(exp_wrapped));
        if (!busy) check("fill_level", 64'(bus.fill_level), 64'(pend.size()));
        acc = v && !busy;
        if (busy) begin
            busy = 0;
            if (wrap_pend) begin
                exp_wrapped = 1;
                wrap_pend = 0;
            end
        end else if (acc) begin
            pend.push_back(b);
            if (pend.size() == 4 || f) emit();
        end else if (f && pend.size() > 0) begin
            emit();
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit f);
        bit acc;
        acc = 0;
        while (!acc) step(1'b1, b, f, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        check("rst mem_we", 64'(bus.mem_we), 64'd0);
        check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst mem_data", 64'(bus.mem_data), 64'd0);
        check("rst fill_level", 64'(bus.fill_level), 64'd0);
        check("rst wrapped", 64'(bus.wrapped), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    bit prev_we = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (bus.mem_we) begin
                check("we_consecutive", 64'(prev_we), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    $display("write addr %0d data 0x%08h (expected addr %0d data 0x%08h)",
                             bus.mem_addr, bus.mem_data, w.addr, w.data);
                    check("mem_addr", 64'(bus.mem_addr), 64'(w.addr));
                    check("mem_data", 64'(bus.mem_data), 64'(w.data));
                end
            end
            prev_we <= bus.mem_we;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.flush    = 1'b0;
        model_clear();
        #3;
        check("init mem_we", 64'(bus.mem_we), 64'd0);
        check("init mem_addr", 64'(bus.mem_addr), 64'd0);
        check("init mem_data", 64'(bus.mem_data), 64'd0);
        check("init wrapped", 64'(bus.wrapped), 64'd0);
        check("init in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic word, then an 8-byte back-to-back stream
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        idle(2);
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        idle(2);

        // Flush alone, flush with nothing pending, flush with a third byte
        send(8'hAA, 0); send(8'hBB, 0); step(1'b0, 8'h00, 1'b1, acc);
        idle(2);
        step(1'b0, 8'h00, 1'b1, acc);
        idle(2);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        idle(2);
        send(8'h5A, 1);
        idle(2);

        // 65 full words starting from address 0 to exercise wrap-around
        do_reset();
        for (int w = 0; w < DEPTH + 1; w++)
            for (int k = 0; k < 4; k++) send(8'($urandom), 0);
        idle(3);

        // Reset between the 2nd and 3rd byte, then during a WRITE cycle
        send(8'hDE, 0); send(8'hAD, 0);
        do_reset();
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        do_reset();
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 0);
        idle(3);

        // Randomized traffic with sporadic flushes and valid gaps
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, acc);
        idle(4);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
